// File: rtl/reg_file_seq.sv
// Burst sequencer in front of reg_file: fills addresses 0..reg_number-1 from the input
// stream, then sweeps reads back out through a small FIFO so the drain runs at one word/cycle.
module reg_file_seq #(
    parameter  int data_width = 16,
    parameter  int reg_number = 8,
    localparam int AW         = $clog2(reg_number)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  rf_en_w,
    output logic [AW-1:0]         rf_reg_select_w,
    output logic [data_width-1:0] rf_data_in,
    output logic                  rf_en_r,
    output logic [AW-1:0]         rf_reg_select_r,
    input  logic [data_width-1:0] rf_data_out
);

    localparam int FD = 4;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                         state;
    logic [AW-1:0]                  wr_cnt;
    logic [AW:0]                    rd_cnt;
    logic [AW-1:0]                  out_cnt;
    logic                           inflight;
    logic [FD-1:0][data_width-1:0]  fifo_mem;
    logic [1:0]                     fifo_wp;
    logic [1:0]                     fifo_rp;
    logic [2:0]                     fifo_count;

    logic wr_fire, rd_fire, push, pop, last_out;

    assign in_ready        = (state == FILL);
    assign wr_fire         = in_valid && in_ready;
    assign rf_en_w         = wr_fire;
    assign rf_reg_select_w = wr_cnt;
    assign rf_data_in      = in_data;

    // Count the read in flight as occupied so the FIFO can never overflow.
    assign rd_fire = (state == DRAIN) && (rd_cnt < (AW+1)'(reg_number)) &&
                     (({2'b00, inflight} + fifo_count) < 3'd4);
    assign rf_en_r         = rd_fire;
    assign rf_reg_select_r = rd_cnt[AW-1:0];

    assign push      = inflight;
    assign out_valid = (fifo_count != 3'd0);
    assign out_data  = fifo_mem[fifo_rp];
    assign pop       = out_valid && out_ready;
    assign last_out  = pop && (out_cnt == AW'(reg_number - 1));
    assign done      = last_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            out_cnt    <= '0;
            inflight   <= 1'b0;
            fifo_mem   <= '0;
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            fifo_count <= '0;
        end else begin
            inflight <= rd_fire;
            if (rd_fire)
                rd_cnt <= rd_cnt + 1'b1;
            if (push) begin
                fifo_mem[fifo_wp] <= rf_data_out;
                fifo_wp           <= fifo_wp + 1'b1;
            end
            if (pop) begin
                fifo_rp <= fifo_rp + 1'b1;
                out_cnt <= out_cnt + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                FILL: begin
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == AW'(reg_number - 1)) begin
                            state  <= DRAIN;
                            wr_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (last_out) begin
                        state   <= FILL;
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench for reg_file_seq: emulates reg_file, models the burst stream behaviour
// and checks the DUT every cycle, plus literal checks per scenario.
module tb_reg_file_seq;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          done;
    logic          rf_en_w;
    logic [AW-1:0] rf_reg_select_w;
    logic [DW-1:0] rf_data_in;
    logic          rf_en_r;
    logic [AW-1:0] rf_reg_select_r;
    logic [DW-1:0] rf_data_out;

    reg_file_seq #(.data_width(DW), .reg_number(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .done(done),
        .rf_en_w(rf_en_w), .rf_reg_select_w(rf_reg_select_w), .rf_data_in(rf_data_in),
        .rf_en_r(rf_en_r), .rf_reg_select_r(rf_reg_select_r), .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    // reg_file stand-in: write at the edge, registered read data one cycle later.
    logic [DW-1:0] rf_mem [N];
    always @(posedge clk) begin
        if (rf_en_w) rf_mem[rf_reg_select_w] <= rf_data_in;
        if (rf_en_r) rf_data_out <= rf_mem[rf_reg_select_r];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural model state
    bit            filling = 1'b1;
    int            wr_idx, rd_idx, out_idx, outstanding, max_out, stall_cnt, first_vld_cyc;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    int            in_cyc[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            filling = 1'b1; wr_idx = 0; rd_idx = 0; out_idx = 0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            chk("in_ready", in_ready, filling);
            chk("rf_en_w", rf_en_w, filling && in_valid);
            if (rf_en_w) begin
                chk("wr_sel", rf_reg_select_w, wr_idx);
                chk("wr_data", rf_data_in, in_data);
            end
            if (filling) begin
                chk("rf_en_r_in_fill", rf_en_r, 0);
                chk("out_valid_in_fill", out_valid, 0);
            end
            if (rf_en_r) begin
                chk("rd_sel", rf_reg_select_r, rd_idx);
                chk("rd_in_range", rd_idx < N, 1);
            end
            outstanding = rd_idx + int'(rf_en_r) - out_idx;
            chk("outstanding_le4", outstanding <= 4, 1);
            if (outstanding > max_out) max_out = outstanding;
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got %0h expected no word", out_data);
                end else chk("out_data", out_data, exp_q[0]);
            end
            chk("done", done, out_valid && out_ready && out_idx == N-1);
            if (out_valid && !out_ready) stall_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;

            // advance the model by the handshakes that complete at the next edge
            if (filling && in_valid) begin
                exp_q.push_back(in_data);
                in_cyc.push_back(cyc);
                wr_idx++;
                if (wr_idx == N) begin
                    filling = 1'b0; wr_idx = 0; rd_idx = 0; out_idx = 0;
                end
            end
            if (rf_en_r) rd_idx++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                out_idx++;
                if (out_idx == N) filling = 1'b1;
            end
        end
    end

    int            done_cyc;
    logic [DW-1:0] done_data;

    task automatic clear_obs();
        got_q.delete(); got_cyc.delete(); in_cyc.delete();
        max_out = 0; stall_cnt = 0; first_vld_cyc = -1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_word(input logic [DW-1:0] d, input bit gap);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin n_checks++; $display("FAIL send_timeout: word %0h never accepted", d); end
        if (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_burst(input logic [DW-1:0] base, input int cnt, input bit gap);
        for (int i = 0; i < cnt; i++) send_word(base + DW'(i), gap);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; done_cyc = cyc; done_data = out_data; end
        end
        #1;
        if (!seen) begin n_checks++; $display("FAIL done_timeout: done never pulsed"); end
    endtask

    task automatic check_burst(input string name, input logic [DW-1:0] base);
        chk({name, "_count"}, got_q.size(), N);
        for (int i = 0; i < N && i < got_q.size(); i++)
            chk({name, "_word"}, got_q[i], base + DW'(i));
        chk({name, "_done_word"}, done_data, base + DW'(N-1));
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_in_ready"}, in_ready, 1);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_rf_en_w"}, rf_en_w, 0);
        chk({name, "_rf_en_r"}, rf_en_r, 0);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_sel_w"}, rf_reg_select_w, 0);
        chk({name, "_sel_r"}, rf_reg_select_r, 0);
    endtask

    task automatic mid_reset(input string name);
        #2 rst_n = 1'b0; in_valid = 1'b0;
        #1 check_reset_vals(name);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        clear_obs();
        #1 check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic burst, back-to-back input, free-flowing output
        clear_obs();
        send_burst(16'h0010, N, 1'b0);
        wait_done();
        check_burst("basic", 16'h0010);
        if (in_cyc.size() == N) begin
            chk("basic_in_span", in_cyc[N-1] - in_cyc[0], N-1);
            chk("basic_latency", first_vld_cyc - in_cyc[N-1], 3);
        end else chk("basic_in_count", in_cyc.size(), N);
        if (got_cyc.size() == N) chk("basic_out_span", got_cyc[N-1] - got_cyc[0], N-1);
        @(posedge clk); #1;

        // input gaps
        clear_obs();
        send_burst(16'h0020, N, 1'b1);
        wait_done();
        check_burst("gaps", 16'h0020);
        if (in_cyc.size() == N) chk("gaps_in_span", in_cyc[N-1] - in_cyc[0], 2*(N-1));
        @(posedge clk); #1;

        // output backpressure mid-drain
        clear_obs();
        send_burst(16'h0040, N, 1'b0);
        for (int t = 0; t < 50 && got_q.size() < 2; t++) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        wait_done();
        check_burst("bp", 16'h0040);
        chk("bp_max_outstanding", max_out, 4);
        chk("bp_stall_cycles", stall_cnt, 6);
        @(posedge clk); #1;

        // back-to-back bursts
        clear_obs();
        send_burst(16'h0060, N, 1'b0);
        wait_done();
        check_burst("b2b_first", 16'h0060);
        clear_obs();
        @(posedge clk); #1;
        send_burst(16'h00A0, N, 1'b0);
        if (in_cyc.size() > 0) chk("b2b_restart_cycle", in_cyc[0] - done_cyc, 1);
        wait_done();
        check_burst("b2b_second", 16'h00A0);
        @(posedge clk); #1;

        // reset after three writes
        send_burst(16'h0070, 3, 1'b0);
        mid_reset("rst_fill");
        clear_obs();
        send_burst(16'h0080, N, 1'b0);
        wait_done();
        check_burst("after_rst_fill", 16'h0080);
        @(posedge clk); #1;

        // reset during drain after two outputs
        clear_obs();
        send_burst(16'h0050, N, 1'b0);
        for (int t = 0; t < 50 && got_q.size() < 2; t++) begin @(posedge clk); #1; end
        mid_reset("rst_drain");
        clear_obs();
        send_burst(16'h0090, N, 1'b0);
        wait_done();
        check_burst("after_rst_drain", 16'h0090);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
